// File: rtl/uart_byte_source.sv
// UART 8N1 receiver + byte FIFO + one-byte-per-request delivery to the t0 core.
// Define UART_PARITY_EN for 8E1 frames (parity state between data and stop).
module uart_byte_source #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                             clk,
  input  logic                             N_reset,
  input  logic                             rx,
  input  logic                             data_request,
  output logic [7:0]                       data,
  output logic                             data_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
  output logic                             framing_err,
  output logic                             overrun_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rx_state_t;

  typedef enum logic {
    DL_ARMED,
    DL_WAIT_LOW
  } dl_state_t;

  logic            rx_s1;
  logic            rx_s2;

  rx_state_t       rx_state;
  rx_state_t       rx_state_n;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_n;
  logic [2:0]      bit_idx;
  logic [2:0]      bit_idx_n;
  logic [7:0]      shreg;
  logic [7:0]      shreg_n;
  logic            push_q;
  logic            push_n;
  logic            ferr_n;
`ifdef UART_PARITY_EN
  logic            par_bad;
  logic            par_bad_n;
`endif

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   level_n;
  logic            empty;
  logic            full;
  logic            pop;
  logic            push_ok;
  logic            overrun_n;

  dl_state_t       dl_state;
  dl_state_t       dl_state_n;

  always_ff @(posedge clk or negedge N_reset) begin
    if (!N_reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
    end
  end

  always_ff @(posedge clk or negedge N_reset) begin
    if (!N_reset) begin
      rx_state    <= RX_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      push_q      <= 1'b0;
      framing_err <= 1'b0;
`ifdef UART_PARITY_EN
      par_bad     <= 1'b0;
`endif
    end else begin
      rx_state    <= rx_state_n;
      cnt         <= cnt_n;
      bit_idx     <= bit_idx_n;
      shreg       <= shreg_n;
      push_q      <= push_n;
      framing_err <= ferr_n;
`ifdef UART_PARITY_EN
      par_bad     <= par_bad_n;
`endif
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    cnt_n      = cnt + CW'(1);
    bit_idx_n  = bit_idx;
    shreg_n    = shreg;
    push_n     = 1'b0;
    ferr_n     = 1'b0;
`ifdef UART_PARITY_EN
    par_bad_n  = par_bad;
`endif
    unique case (rx_state)
      RX_IDLE: begin
        cnt_n = '0;
        if (!rx_s2) begin
          rx_state_n = RX_START;
          bit_idx_n  = '0;
        end
      end
      RX_START: begin
        if (cnt == HALF_END) begin
          cnt_n      = '0;
          // a high line at mid-start is a glitch, not a frame
          rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt == BIT_END) begin
          cnt_n     = '0;
          shreg_n   = {rx_s2, shreg[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
            rx_state_n = RX_PARITY;
`else
            rx_state_n = RX_STOP;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: begin
        if (cnt == BIT_END) begin
          cnt_n      = '0;
          par_bad_n  = ^{rx_s2, shreg};
          rx_state_n = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (cnt == BIT_END) begin
          cnt_n      = '0;
          rx_state_n = RX_IDLE;
`ifdef UART_PARITY_EN
          if (rx_s2 && !par_bad) push_n = 1'b1;
          else                   ferr_n = 1'b1;
`else
          if (rx_s2) push_n = 1'b1;
          else       ferr_n = 1'b1;
`endif
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  assign empty     = (fifo_level == '0);
  assign full      = (fifo_level == FULL_LVL);
  assign pop       = (dl_state == DL_ARMED) && data_request && !empty;
  assign push_ok   = push_q && (!full || pop);
  assign overrun_n = push_q && full && !pop;

  always_comb begin
    level_n = fifo_level;
    unique case ({push_ok, pop})
      2'b10:   level_n = fifo_level + LW'(1);
      2'b01:   level_n = fifo_level - LW'(1);
      default: level_n = fifo_level;
    endcase
  end

  always_ff @(posedge clk or negedge N_reset) begin
    if (!N_reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      overrun_err <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      fifo_level  <= level_n;
      overrun_err <= overrun_n;
    end
  end

  always_ff @(posedge clk or negedge N_reset) begin
    if (!N_reset) begin
      dl_state   <= DL_ARMED;
      data       <= '0;
      data_ready <= 1'b0;
    end else begin
      dl_state   <= dl_state_n;
      data_ready <= pop;
      if (pop) data <= mem[rd_ptr];
    end
  end

  always_comb begin
    dl_state_n = dl_state;
    unique case (dl_state)
      DL_ARMED:    if (pop) dl_state_n = DL_WAIT_LOW;
      DL_WAIT_LOW: if (!data_request) dl_state_n = DL_ARMED;
      default:     dl_state_n = DL_ARMED;
    endcase
  end

endmodule

// File: tb/tb_uart_byte_source.sv
// Scoreboard bench for uart_byte_source: queue model of FIFO + request rules.
// Random frames/glitches/requests on top of directed cases.
module tb_uart_byte_source;

  localparam int CPB   = 8;
  localparam int DEPTH = 4;
`ifdef UART_PARITY_EN
  localparam bit PARITY = 1'b1;
`else
  localparam bit PARITY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       N_reset = 1'b0;
  logic       rx = 1'b1;
  logic       data_request = 1'b0;
  logic [7:0] data;
  logic       data_ready;
  logic [2:0] fifo_level;
  logic       framing_err;
  logic       overrun_err;

  int checks = 0;
  int errors = 0;
  int fe_seen = 0;
  int ov_seen = 0;
  int fe_exp = 0;
  int ov_exp = 0;
  bit pend = 1'b0;

  logic [7:0] mq[$];
  logic [7:0] exp_q[$];

  logic [7:0] rb;
  bit         rst_ok;
  bit         rpar_ok;
  int         act;

  always #5 clk = ~clk;

  uart_byte_source #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .N_reset(N_reset),
    .rx(rx),
    .data_request(data_request),
    .data(data),
    .data_ready(data_ready),
    .fifo_level(fifo_level),
    .framing_err(framing_err),
    .overrun_err(overrun_err)
  );

  task automatic chk(string name, int act_v, int exp_v);
    checks++;
    if (act_v != exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act_v, exp_v);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic post_check;
    chk("fifo_level", int'(fifo_level), mq.size());
    chk("framing_err_count", fe_seen, fe_exp);
    chk("overrun_err_count", ov_seen, ov_exp);
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    repeat (CPB) tick;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input bit par_ok, input bit aborted);
    bit good;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    if (PARITY) send_bit(^b ^ !par_ok);
    send_bit(stop);
    rx = 1'b1;
    good = stop && (par_ok || !PARITY);
    if (!aborted) begin
      if (!good) fe_exp++;
      else if (pend && mq.size() == 0) begin
        exp_q.push_back(b);
        pend = 1'b0;
      end else if (mq.size() < DEPTH) mq.push_back(b);
      else ov_exp++;
    end
    repeat (2 * CPB) tick;
    post_check();
  endtask

  task automatic glitch(input int n);
    rx = 1'b0;
    repeat (n) tick;
    rx = 1'b1;
    repeat (2 * CPB) tick;
    post_check();
  endtask

  task automatic do_request(input int hold);
    bit exp_d;
    exp_d = (mq.size() > 0);
    if (exp_d) exp_q.push_back(mq.pop_front());
    data_request = 1'b1;
    tick;
    chk("request_latency", int'(data_ready), int'(exp_d));
    repeat (hold - 1) tick;
    data_request = 1'b0;
    repeat (2) tick;
    chk("level_after_request", int'(fifo_level), mq.size());
  endtask

  task automatic chk_reset_outputs;
    chk("reset_data", int'(data), 0);
    chk("reset_data_ready", int'(data_ready), 0);
    chk("reset_fifo_level", int'(fifo_level), 0);
    chk("reset_framing_err", int'(framing_err), 0);
    chk("reset_overrun_err", int'(overrun_err), 0);
  endtask

  always @(negedge clk) begin
    if (framing_err) fe_seen++;
    if (overrun_err) ov_seen++;
    if (data_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_data_ready: got strobe with data 0x%0h, required none", data);
      end else begin
        chk("data", int'(data), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #12;
    chk_reset_outputs();
    tick;
    N_reset = 1'b1;
    repeat (3) tick;

    send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    do_request(3);

    send_frame(8'h01, 1'b1, 1'b1, 1'b0);
    send_frame(8'h02, 1'b1, 1'b1, 1'b0);
    send_frame(8'h03, 1'b1, 1'b1, 1'b0);
    do_request(6);
    do_request(2);
    do_request(1);

    for (int i = 0; i < 5; i++) send_frame(8'h10 + 8'(i), 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) do_request(2);

    send_frame(8'h55, 1'b0, 1'b1, 1'b0);
    send_frame(8'h66, 1'b1, 1'b1, 1'b0);
    do_request(1);

    glitch(2);
    glitch(1);

    data_request = 1'b1;
    pend = 1'b1;
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
    chk("pending_served", int'(pend), 0);
    data_request = 1'b0;
    repeat (2) tick;

    send_frame(8'h77, 1'b1, 1'b1, 1'b0);
    fork
      send_frame(8'hFE, 1'b1, 1'b1, 1'b1);
      begin
        repeat (30) tick;
        N_reset = 1'b0;
        mq.delete();
        #1;
        chk_reset_outputs();
        tick;
        N_reset = 1'b1;
      end
    join
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
    do_request(2);

    if (PARITY) begin
      send_frame(8'h07, 1'b1, 1'b1, 1'b0);
      send_frame(8'h07, 1'b1, 1'b0, 1'b0);
      do_request(1);
    end

    for (int it = 0; it < 60; it++) begin
      act = $urandom_range(0, 7);
      if (act <= 4) begin
        rb      = 8'($urandom);
        rst_ok  = ($urandom_range(0, 7) != 0);
        rpar_ok = ($urandom_range(0, 7) != 0);
        send_frame(rb, rst_ok, rpar_ok, 1'b0);
      end else if (act == 5) begin
        glitch($urandom_range(1, 2));
      end else begin
        do_request($urandom_range(1, 4));
      end
    end

    while (mq.size() > 0) do_request(1);
    repeat (4) tick;
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
